// File: rtl/data_mem_resp.sv
// data_mem_resp: responder end of the core's data-memory port.
// Word RAM plus a small I/O block (64-bit timer, compare/interrupt, tohost halt).
// Load data is combinational so the MEM/WB register can sample it at the next edge.
module data_mem_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] IO_BASE    = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o,
    output logic        halt_o,
    output logic [31:0] halt_code_o,
    output logic        bus_err_o
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [31:0] RAM_WORDS = 32'(DEPTH);
    // One past the last decoded I/O offset (TOHOST at 0x10).
    localparam logic [31:0] IO_SPAN   = 32'h0000_0014;

    // Word select within the I/O block (offset bits [4:2]).
    localparam logic [2:0] SEL_MTIME_LO = 3'd0;
    localparam logic [2:0] SEL_MTIME_HI = 3'd1;
    localparam logic [2:0] SEL_MTIMECMP = 3'd2;
    localparam logic [2:0] SEL_CTRL     = 3'd3;
    localparam logic [2:0] SEL_TOHOST   = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];

    logic [31:0] r_mtime_lo;
    logic [31:0] r_mtime_hi;
    logic [31:0] r_mtimecmp;
    logic        r_en;
    logic        r_pend;
    logic        r_ie;
    logic        r_halt;
    logic [31:0] r_halt_code;
    logic        r_bus_err;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                  w_misaligned;
    logic                  w_ram_hit;
    logic                  w_io_hit;
    logic                  w_unmapped;
    logic [31:0]           w_io_off;
    logic [2:0]            w_io_sel;
    logic [DEPTH_LOG2-1:0] w_ram_idx;

    logic w_load;
    logic w_store;
    logic w_ram_we;
    logic w_wr_lo;
    logic w_wr_hi;
    logic w_wr_cmp;
    logic w_wr_ctrl;
    logic w_wr_tohost;

    assign w_ram_idx = data_addr_i[DEPTH_LOG2+1:2];

    // Classify the address: RAM, one of the I/O words, or unmapped.
    always_comb begin
        w_misaligned = (data_addr_i[1:0] != 2'b00);
        w_io_off     = data_addr_i - IO_BASE;
        w_ram_hit    = !w_misaligned
                    && (data_addr_i[31:28] == 4'h0)
                    && ({6'b0, data_addr_i[27:2]} < RAM_WORDS);
        // RAM wins if a parameter choice ever makes the two windows overlap.
        w_io_hit     = !w_misaligned && !w_ram_hit && (w_io_off < IO_SPAN);
        w_io_sel     = w_io_off[4:2];
        w_unmapped   = !w_ram_hit && !w_io_hit;
    end

    // Per-target write strobes; unmapped/misaligned stores raise none of them.
    always_comb begin
        w_load      = data_ce_i && !data_we_i;
        w_store     = data_ce_i && data_we_i;
        w_wr_lo     = w_store && w_io_hit && (w_io_sel == SEL_MTIME_LO);
        w_wr_hi     = w_store && w_io_hit && (w_io_sel == SEL_MTIME_HI);
        w_wr_cmp    = w_store && w_io_hit && (w_io_sel == SEL_MTIMECMP);
        w_wr_ctrl   = w_store && w_io_hit && (w_io_sel == SEL_CTRL);
        w_wr_tohost = w_store && w_io_hit && (w_io_sel == SEL_TOHOST);
        // RAM has no reset, so a store presented while rst is low is dropped here.
        w_ram_we    = rst && w_store && w_ram_hit;
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;

    // Combinational read mux; forced to zero for non-loads, bad addresses and reset.
    always_comb begin
        w_rdata = 32'h0;
        if (rst && w_load) begin
            if (w_ram_hit) begin
                w_rdata = r_mem[w_ram_idx];
            end else if (w_io_hit) begin
                unique case (w_io_sel)
                    SEL_MTIME_LO: w_rdata = r_mtime_lo;
                    SEL_MTIME_HI: w_rdata = r_mtime_hi;
                    SEL_MTIMECMP: w_rdata = r_mtimecmp;
                    SEL_CTRL:     w_rdata = {29'h0, r_ie, r_pend, r_en};
                    default:      w_rdata = 32'h0; // TOHOST is write-only
                endcase
            end
        end
    end

    assign data_o = w_rdata;

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    // Word write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_idx] <= data_i;
        end
    end

    // ------------------------------------------------------------------
    // Timer and compare next-state
    // ------------------------------------------------------------------
    logic [63:0] w_mtime_q;
    logic [63:0] w_mtime_d;
    logic        w_cmp_hit;
    logic        w_pend_clr;
    logic        w_pend_d;

    assign w_mtime_q = {r_mtime_hi, r_mtime_lo};

    // A store to either half replaces the whole increment: no carry that cycle.
    always_comb begin
        w_mtime_d = w_mtime_q;
        if (w_wr_lo) begin
            w_mtime_d = {r_mtime_hi, data_i};
        end else if (w_wr_hi) begin
            w_mtime_d = {data_i, r_mtime_lo};
        end else if (r_en) begin
            w_mtime_d = w_mtime_q + 64'd1;
        end
    end

    // Compare on the current low word; a same-cycle set beats a W1C clear.
    always_comb begin
        w_cmp_hit  = r_en && (r_mtime_lo == r_mtimecmp);
        w_pend_clr = w_wr_ctrl && data_i[1];
        w_pend_d   = r_pend;
        if (w_cmp_hit) begin
            w_pend_d = 1'b1;
        end else if (w_pend_clr) begin
            w_pend_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register update
    // ------------------------------------------------------------------
    // Timer, compare and control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtime_lo <= 32'h0;
            r_mtime_hi <= 32'h0;
            r_mtimecmp <= 32'hFFFF_FFFF;
            r_en       <= 1'b0;
            r_pend     <= 1'b0;
            r_ie       <= 1'b0;
        end else begin
            r_mtime_lo <= w_mtime_d[31:0];
            r_mtime_hi <= w_mtime_d[63:32];
            r_pend     <= w_pend_d;
            if (w_wr_cmp) begin
                r_mtimecmp <= data_i;
            end
            if (w_wr_ctrl) begin
                r_en <= data_i[0];
                r_ie <= data_i[2];
            end
        end
    end

    // Sticky halt flag with last-written tohost code, and sticky bus error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halt      <= 1'b0;
            r_halt_code <= 32'h0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_wr_tohost) begin
                r_halt      <= 1'b1;
                r_halt_code <= data_i;
            end
            if (data_ce_i && w_unmapped) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign irq_o       = r_pend && r_ie;
    assign halt_o      = r_halt;
    assign halt_code_o = r_halt_code;
    assign bus_err_o   = r_bus_err;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed table, corner-case sequences and random traffic
// for data_mem_resp, checked against a behavioural model of the memory map.
module tb_data_mem_resp;

    localparam int unsigned DEPTH_LOG2 = 10;
    localparam logic [31:0] IOB        = 32'h1000_0000;
    localparam logic [31:0] A_LO       = IOB;
    localparam logic [31:0] A_HI       = IOB + 32'h4;
    localparam logic [31:0] A_CMP      = IOB + 32'h8;
    localparam logic [31:0] A_CTRL     = IOB + 32'hC;
    localparam logic [31:0] A_TOH      = IOB + 32'h10;
    localparam logic [31:0] RAM_BYTES  = 32'd4 << DEPTH_LOG2;

    localparam int K_RAM  = 0;
    localparam int K_LO   = 1;
    localparam int K_HI   = 2;
    localparam int K_CMP  = 3;
    localparam int K_CTRL = 4;
    localparam int K_TOH  = 5;
    localparam int K_BAD  = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data_o;
    logic        irq;
    logic        halt;
    logic [31:0] code;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the visible state.
    logic [63:0] m_time;
    logic [31:0] m_cmp;
    logic        m_en;
    logic        m_pend;
    logic        m_ie;
    logic        m_halt;
    logic [31:0] m_code;
    logic        m_err;
    logic [31:0] m_ram [int];

    typedef struct {
        string       name;
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_halt;
        logic [31:0] exp_code;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    data_mem_resp #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .IO_BASE   (IOB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_ce_i  (ce),
        .data_we_i  (we),
        .data_addr_i(addr),
        .data_i     (wdata),
        .data_o     (data_o),
        .irq_o      (irq),
        .halt_o     (halt),
        .halt_code_o(code),
        .bus_err_o  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic int classify(input logic [31:0] a);
        logic [31:0] off;
        if (a[1:0] != 2'b00) return K_BAD;
        if (a < RAM_BYTES) return K_RAM;
        off = a - IOB;
        if (off < 32'd20) return K_LO + int'(off >> 2);
        return K_BAD;
    endfunction

    function automatic void model_reset();
        m_time = 64'h0;
        m_cmp  = 32'hFFFF_FFFF;
        m_en   = 1'b0;
        m_pend = 1'b0;
        m_ie   = 1'b0;
        m_halt = 1'b0;
        m_code = 32'h0;
        m_err  = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic c, input logic w, input logic [31:0] a);
        int k;
        int idx;
        if (!c || w) return 32'h0;
        k   = classify(a);
        idx = int'(a >> 2);
        case (k)
            K_RAM:   return m_ram.exists(idx) ? m_ram[idx] : 32'hxxxx_xxxx;
            K_LO:    return m_time[31:0];
            K_HI:    return m_time[63:32];
            K_CMP:   return m_cmp;
            K_CTRL:  return {29'h0, m_ie, m_pend, m_en};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the memory map, from the architectural rules.
    function automatic void model_edge(input logic c, input logic w, input logic [31:0] a,
                                       input logic [31:0] d);
        int          k;
        logic [63:0] nt;
        logic        set;
        logic        clr;
        k   = classify(a);
        nt  = m_en ? m_time + 64'd1 : m_time;
        set = m_en && (m_time[31:0] == m_cmp);
        clr = 1'b0;
        if (c && k == K_BAD) m_err = 1'b1;
        if (c && w) begin
            case (k)
                K_RAM:  m_ram[int'(a >> 2)] = d;
                K_LO:   nt = {m_time[63:32], d};
                K_HI:   nt = {d, m_time[31:0]};
                K_CMP:  m_cmp = d;
                K_CTRL: begin
                    m_en = d[0];
                    m_ie = d[2];
                    clr  = d[1];
                end
                K_TOH:  begin
                    m_halt = 1'b1;
                    m_code = d;
                end
                default: ;
            endcase
        end
        m_time = nt;
        if (set) m_pend = 1'b1;
        else if (clr) m_pend = 1'b0;
    endfunction

    // One bus cycle: check the combinational read, clock, check registered outputs.
    task automatic step(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
        ce    = c;
        we    = w;
        addr  = a;
        wdata = d;
        #1;
        rd = data_o;
        check32($sformatf("data_o @%h", a), data_o, model_read(c, w, a));
        @(posedge clk);
        model_edge(c, w, a, d);
        #1;
        check1("irq_o", irq, m_pend & m_ie);
        check1("halt_o", halt, m_halt);
        check32("halt_code_o", code, m_code);
        check1("bus_err_o", err, m_err);
    endtask

    task automatic do_reset();
        #2;
        rst   = 1'b0;
        ce    = 1'b1;
        we    = 1'b0;
        addr  = 32'h10;
        #1;
        check1("rst halt_o", halt, 1'b0);
        check32("rst halt_code_o", code, 32'h0);
        check1("rst bus_err_o", err, 1'b0);
        check1("rst irq_o", irq, 1'b0);
        check32("rst data_o", data_o, 32'h0);
        @(posedge clk);
        #3;
        ce  = 1'b0;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic add(input string n, input logic c, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input logic h,
                       input logic [31:0] hc, input logic e);
        vec_t v;
        v.name     = n;
        v.ce       = c;
        v.we       = w;
        v.addr     = a;
        v.wdata    = d;
        v.exp_rd   = rd;
        v.exp_halt = h;
        v.exp_code = hc;
        v.exp_err  = e;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        logic        c;
        logic        w;
        int          kind;

        rst   = 1'b0;
        ce    = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Directed table, timer disabled throughout.
        add("st_ram0",    1, 1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0,         0, 32'h0,  0);
        add("st_ram10",   1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 32'h0,  0);
        add("ld_ram10",   1, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 32'h0,  0);
        add("st_ram14",   1, 1, 32'h0000_0014, 32'h0,         32'h0,         0, 32'h0,  0);
        add("ld_ram14",   1, 0, 32'h0000_0014, 32'h0,         32'h0,         0, 32'h0,  0);
        add("st_ramtop",  1, 1, RAM_BYTES - 4, 32'h0BAD_F00D, 32'h0,         0, 32'h0,  0);
        add("ld_ramtop",  1, 0, RAM_BYTES - 4, 32'h0,         32'h0BAD_F00D, 0, 32'h0,  0);
        add("noce_ld",    0, 0, 32'h0000_0010, 32'h0,         32'h0,         0, 32'h0,  0);
        add("st_toh1",    1, 1, A_TOH,         32'h1,         32'h0,         1, 32'h1,  0);
        add("ld_toh",     1, 0, A_TOH,         32'h0,         32'h0,         1, 32'h1,  0);
        add("st_toh2a",   1, 1, A_TOH,         32'h2A,        32'h0,         1, 32'h2A, 0);
        add("st_cmp",     1, 1, A_CMP,         32'h1234,      32'h0,         1, 32'h2A, 0);
        add("ld_cmp",     1, 0, A_CMP,         32'h0,         32'h1234,      1, 32'h2A, 0);
        add("st_ctrl4",   1, 1, A_CTRL,        32'hFFFF_FFFC, 32'h0,         1, 32'h2A, 0);
        add("ld_ctrl",    1, 0, A_CTRL,        32'h0,         32'h4,         1, 32'h2A, 0);
        add("ld_lo_off",  1, 0, A_LO,          32'h0,         32'h0,         1, 32'h2A, 0);
        add("st_ctrl0",   1, 1, A_CTRL,        32'h0,         32'h0,         1, 32'h2A, 0);
        add("ld_misal",   1, 0, 32'h0000_0002, 32'h0,         32'h0,         1, 32'h2A, 1);
        add("st_unmap",   1, 1, 32'h2000_0010, 32'h5555_5555, 32'h0,         1, 32'h2A, 1);
        add("ld_after_u", 1, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1, 32'h2A, 1);
        add("st_misal",   1, 1, 32'h0000_0012, 32'h1111_1111, 32'h0,         1, 32'h2A, 1);
        add("ld_after_m", 1, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1, 32'h2A, 1);
        add("st_ramend",  1, 1, RAM_BYTES,     32'h7777_7777, 32'h0,         1, 32'h2A, 1);
        add("ld_ram0",    1, 0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1, 32'h2A, 1);
        add("ld_io14",    1, 0, IOB + 32'h14,  32'h0,         32'h0,         1, 32'h2A, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v     = vecs[i];
            ce    = v.ce;
            we    = v.we;
            addr  = v.addr;
            wdata = v.wdata;
            #1;
            check32({v.name, ":data_o"}, data_o, v.exp_rd);
            @(posedge clk);
            model_edge(v.ce, v.we, v.addr, v.wdata);
            #1;
            check1({v.name, ":halt_o"}, halt, v.exp_halt);
            check32({v.name, ":halt_code_o"}, code, v.exp_code);
            check1({v.name, ":bus_err_o"}, err, v.exp_err);
        end
        ce = 1'b0;

        // Compare/interrupt: count to MTIMECMP, then clear.
        do_reset();
        step(1, 1, A_CTRL, 32'h5, rd);
        step(1, 1, A_CMP, 32'd20, rd);
        step(1, 1, A_LO, 32'h0, rd);
        for (int i = 0; i < 20; i++) step(0, 0, 32'h0, 32'h0, rd);
        check1("irq before match edge", irq, 1'b0);
        step(1, 0, A_LO, 32'h0, rd);
        check32("mtime_lo after 20 edges", rd, 32'd20);
        check1("irq after match edge", irq, 1'b1);
        step(1, 0, A_CTRL, 32'h0, rd);
        check32("ctrl en|pend|ie", rd, 32'h7);
        step(1, 1, A_CTRL, 32'h7, rd);
        check1("irq after w1c", irq, 1'b0);

        // Set and clear in the same cycle: set wins.
        step(1, 1, A_CMP, 32'd101, rd);
        step(1, 1, A_LO, 32'd100, rd);
        step(0, 0, 32'h0, 32'h0, rd);
        step(1, 1, A_CTRL, 32'h7, rd);
        check1("irq set beats clear", irq, 1'b1);

        // Low-word wrap carries into high; a HI store suppresses the carry.
        step(1, 1, A_HI, 32'h0, rd);
        step(1, 1, A_LO, 32'hFFFF_FFFF, rd);
        step(0, 0, 32'h0, 32'h0, rd);
        step(1, 0, A_LO, 32'h0, rd);
        check32("lo after wrap", rd, 32'h0);
        step(1, 0, A_HI, 32'h0, rd);
        check32("hi after wrap", rd, 32'h1);
        step(1, 1, A_LO, 32'hFFFF_FFFF, rd);
        step(1, 1, A_HI, 32'h5, rd);
        step(1, 0, A_LO, 32'h0, rd);
        check32("lo held by hi store", rd, 32'hFFFF_FFFF);
        step(1, 0, A_HI, 32'h0, rd);
        check32("hi 5 then carry", rd, 32'h6);

        // Asynchronous reset mid-activity, with stores presented during reset.
        step(1, 1, A_TOH, 32'h9, rd);
        step(1, 1, A_HI, 32'h0, rd);
        step(1, 1, A_CTRL, 32'h1, rd);
        step(1, 1, A_LO, 32'd37, rd);
        ce   = 1'b1;
        we   = 1'b0;
        addr = A_LO;
        #1;
        check32("mtime before reset", data_o, 32'd37);
        check1("halt before reset", halt, 1'b1);
        we    = 1'b1;
        addr  = A_TOH;
        wdata = 32'h77;
        #1;
        rst = 1'b0;
        #1;
        check1("async rst halt_o", halt, 1'b0);
        check32("async rst halt_code_o", code, 32'h0);
        check1("async rst bus_err_o", err, 1'b0);
        check1("async rst irq_o", irq, 1'b0);
        check32("async rst data_o", data_o, 32'h0);
        addr  = 32'h10;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        check1("halt held in reset", halt, 1'b0);
        #2;
        ce  = 1'b0;
        we  = 1'b0;
        rst = 1'b1;
        model_reset();
        step(1, 0, 32'h10, 32'h0, rd);
        check32("ram store dropped in reset", rd, 32'hDEAD_BEEF);
        step(1, 0, A_LO, 32'h0, rd);
        check32("mtime_lo reset", rd, 32'h0);
        step(1, 0, A_CMP, 32'h0, rd);
        check32("mtimecmp reset", rd, 32'hFFFF_FFFF);
        step(1, 0, A_CTRL, 32'h0, rd);
        check32("ctrl reset", rd, 32'h0);

        // Random traffic against the model; bad addresses only in the second half.
        for (int i = 0; i < 16; i++) step(1, 1, 32'(i) << 2, $urandom, rd);
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, (i < 200) ? 8 : 9);
            d    = $urandom;
            case (kind)
                0, 1, 2, 3: a = 32'($urandom_range(0, 15)) << 2;
                4: a = A_LO;
                5: a = A_HI;
                6: a = A_CMP;
                7: a = A_CTRL;
                8: a = A_TOH;
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                        1: a = 32'h2000_0000 | (32'($urandom_range(0, 15)) << 2);
                        2: a = IOB + 32'h14;
                        default: a = RAM_BYTES + (32'($urandom_range(0, 15)) << 2);
                    endcase
                end
            endcase
            if (kind == 6) d = m_time[31:0] + 32'($urandom_range(0, 6));
            if (kind == 4 && $urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            if (kind == 7) d[0] = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            step(c, w, a, d, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
